// File: rtl/exc_pkg.sv
// Shared types and constants for the LEGv8 exception control unit.
package exc_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HANDLER = 2'd1,
        LOCKUP  = 2'd2
    } exc_state_t;

    localparam logic [63:0] ESR_INV_OP       = 64'h1;
    localparam logic [63:0] ESR_IRQ          = 64'h2;
    localparam logic [63:0] ESR_DOUBLE_FAULT = 64'h3;

    localparam logic [1:0] SYS_ELR  = 2'b00;
    localparam logic [1:0] SYS_ESR  = 2'b01;
    localparam logic [1:0] SYS_CNT  = 2'b10;
    localparam logic [1:0] SYS_ZERO = 2'b11;

    localparam logic [63:0] VECTOR_ADDR_DEF = 64'hD8;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer for the asynchronous interrupt line plus a rising-edge detector.
module irq_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic ext_irq,
    output logic irq_rise
);

    logic r_s1, r_s2, r_s2_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s2_d <= 1'b0;
        end else begin
            r_s1   <= ext_irq;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    // A held-high line yields a single pulse; a fresh low->high is needed to retrigger.
    assign irq_rise = r_s2 & ~r_s2_d;

endmodule

// File: rtl/exc_unit.sv
// Exception control unit: detects invalid-op / IRQ, holds ELR/ESR/count,
// redirects the PC and kills the faulting instruction's writeback.
module exc_unit
    import exc_pkg::*;
#(
    parameter int             N           = 64,
    parameter logic [N-1:0]   VECTOR_ADDR = N'(VECTOR_ADDR_DEF),
    parameter int             CNT_W       = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] pc,
    input  logic         inv_op,
    input  logic         eret,
    input  logic         mrs,
    input  logic [1:0]   sys_sel,
    input  logic         ext_irq,
    output logic         exc_taken,
    output logic         eret_taken,
    output logic [N-1:0] pc_override,
    output logic         kill_wb,
    output logic [N-1:0] mrs_data,
    output logic         in_handler,
    output logic         lockup
);

    exc_state_t         r_state, w_next;
    logic [N-1:0]       r_elr, r_esr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_irq_pend;
    logic               w_irq_rise;
    logic               w_exc, w_take_irq;
    logic [N-1:0]       w_code;
    logic               w_unused_mrs;

    // mrs only steers the regfile write-data mux outside this block.
    assign w_unused_mrs = mrs;

    irq_sync u_irq_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .ext_irq  (ext_irq),
        .irq_rise (w_irq_rise)
    );

    always_comb begin
        w_next      = r_state;
        w_exc       = 1'b0;
        w_take_irq  = 1'b0;
        w_code      = N'(ESR_INV_OP);
        eret_taken  = 1'b0;
        kill_wb     = 1'b0;
        pc_override = '0;
        case (r_state)
            RUN: begin
                // ERET outside a handler is itself an invalid op.
                if (inv_op || eret) begin
                    w_exc = 1'b1;
                end else if (r_irq_pend) begin
                    w_exc      = 1'b1;
                    w_take_irq = 1'b1;
                    w_code     = N'(ESR_IRQ);
                end
                if (w_exc) begin
                    kill_wb     = 1'b1;
                    pc_override = VECTOR_ADDR;
                    w_next      = HANDLER;
                end
            end
            HANDLER: begin
                if (inv_op) begin
                    kill_wb = 1'b1;
                    w_next  = LOCKUP;
                end else if (eret) begin
                    eret_taken  = 1'b1;
                    pc_override = r_elr;
                    w_next      = RUN;
                end
            end
            LOCKUP: begin
                kill_wb     = 1'b1;
                pc_override = pc;
            end
            default: w_next = RUN;
        endcase
    end

    assign exc_taken  = w_exc;
    assign in_handler = (r_state == HANDLER);
    assign lockup     = (r_state == LOCKUP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= RUN;
            r_elr      <= '0;
            r_esr      <= '0;
            r_cnt      <= '0;
            r_irq_pend <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_exc) begin
                r_elr <= pc;
                r_esr <= w_code;
                if (r_cnt != '1)
                    r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == HANDLER && inv_op)
                r_esr <= N'(ESR_DOUBLE_FAULT);
            // A new edge wins over the clear so it is never lost.
            r_irq_pend <= w_irq_rise | (r_irq_pend & ~w_take_irq);
        end
    end

    always_comb begin
        mrs_data = '0;
        case (sys_sel)
            SYS_ELR:  mrs_data = r_elr;
            SYS_ESR:  mrs_data = r_esr;
            SYS_CNT:  mrs_data = N'(r_cnt);
            default:  mrs_data = '0;
        endcase
    end

endmodule

// File: tb/tb_exc_unit.sv
// Randomized self-checking bench for exc_unit against a behavioural model.
module tb_exc_unit;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] pc = '0;
    logic        inv_op = 1'b0, eret = 1'b0, mrs = 1'b0, ext_irq = 1'b0;
    logic [1:0]  sys_sel = 2'b00;
    logic        exc_taken, eret_taken, kill_wb, in_handler, lockup;
    logic [63:0] pc_override, mrs_data;

    int n_chk = 0;
    int n_err = 0;

    // model state: 0 = RUN, 1 = HANDLER, 2 = LOCKUP
    int          m_st;
    logic [63:0] m_elr, m_esr;
    int          m_cnt;
    bit          m_pend;
    bit          m_h0, m_h1, m_h2;   // ext_irq as sampled at the last three edges

    exc_unit #(.N(64), .VECTOR_ADDR(64'hD8), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .pc(pc), .inv_op(inv_op), .eret(eret),
        .mrs(mrs), .sys_sel(sys_sel), .ext_irq(ext_irq),
        .exc_taken(exc_taken), .eret_taken(eret_taken), .pc_override(pc_override),
        .kill_wb(kill_wb), .mrs_data(mrs_data), .in_handler(in_handler), .lockup(lockup)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_elr = '0; m_esr = '0; m_cnt = 0; m_pend = 0;
        m_h0 = 0; m_h1 = 0; m_h2 = 0;
    endtask

    // Compare every output against what the rules say for the current state and inputs.
    task automatic check_outputs();
        bit e_exc, e_eret, e_kill;
        logic [63:0] e_pco, e_mrs;
        e_exc = 0; e_eret = 0; e_kill = 0; e_pco = '0;
        if (m_st == 0 && (inv_op || eret || m_pend)) begin
            e_exc = 1; e_kill = 1; e_pco = 64'hD8;
        end else if (m_st == 1 && inv_op) begin
            e_kill = 1;
        end else if (m_st == 1 && eret) begin
            e_eret = 1; e_pco = m_elr;
        end else if (m_st == 2) begin
            e_kill = 1; e_pco = pc;
        end
        case (sys_sel)
            2'd0: e_mrs = m_elr;
            2'd1: e_mrs = m_esr;
            2'd2: e_mrs = 64'(m_cnt);
            default: e_mrs = '0;
        endcase
        chk("exc_taken",   {63'b0, exc_taken},  {63'b0, e_exc});
        chk("eret_taken",  {63'b0, eret_taken}, {63'b0, e_eret});
        chk("kill_wb",     {63'b0, kill_wb},    {63'b0, e_kill});
        chk("pc_override", pc_override,         e_pco);
        chk("mrs_data",    mrs_data,            e_mrs);
        chk("in_handler",  {63'b0, in_handler}, {63'b0, 1'(m_st == 1)});
        chk("lockup",      {63'b0, lockup},     {63'b0, 1'(m_st == 2)});
    endtask

    task automatic drive(input logic [63:0] p, input bit iv, input bit er,
                         input bit ms, input logic [1:0] sel, input bit irq);
        pc = p; inv_op = iv; eret = er; mrs = ms; sys_sel = sel; ext_irq = irq;
        #1;
        check_outputs();
    endtask

    // Advance one clock; the model takes its step with the inputs held across the edge.
    task automatic tick();
        bit rise, took_irq;
        @(posedge clk);
        rise = m_h1 && !m_h2;
        took_irq = 0;
        case (m_st)
            0: if (inv_op || eret) begin
                   m_elr = pc; m_esr = 64'h1; m_st = 1;
                   if (m_cnt < (1 << CW) - 1) m_cnt++;
               end else if (m_pend) begin
                   m_elr = pc; m_esr = 64'h2; m_st = 1; took_irq = 1;
                   if (m_cnt < (1 << CW) - 1) m_cnt++;
               end
            1: if (inv_op) begin m_esr = 64'h3; m_st = 2; end
               else if (eret) m_st = 0;
            default: ;
        endcase
        m_pend = rise || (m_pend && !took_irq);
        m_h2 = m_h1; m_h1 = m_h0; m_h0 = ext_irq;
        @(negedge clk);
    endtask

    task automatic do_reset();
        pc = '0; inv_op = 0; eret = 0; mrs = 0; sys_sel = 2'd0; ext_irq = 0;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_outputs", {59'b0, exc_taken, eret_taken, kill_wb, in_handler, lockup}, 64'h0);
        chk("rst_pco", pc_override, 64'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int lk;
        do_reset();

        // Invalid op from RUN
        drive(64'h40, 1, 0, 1, 2'd0, 0);
        chk("inv_vec", pc_override, 64'hD8);
        chk("inv_exc", {63'b0, exc_taken}, 64'h1);
        tick();
        drive(64'hD8, 0, 0, 1, 2'd0, 0);
        chk("hdl_state", {63'b0, in_handler}, 64'h1);
        chk("mrs_elr", mrs_data, 64'h40);
        drive(64'hD8, 0, 0, 1, 2'd1, 0);
        chk("mrs_esr", mrs_data, 64'h1);
        drive(64'hD8, 0, 0, 1, 2'd2, 0);
        chk("mrs_cnt", mrs_data, 64'h1);
        tick();

        // ERET back
        drive(64'hDC, 0, 1, 0, 2'd0, 0);
        chk("eret_pco", pc_override, 64'h40);
        chk("eret_tk", {63'b0, eret_taken}, 64'h1);
        tick();
        drive(64'h40, 0, 0, 0, 2'd0, 0);
        chk("run_kill", {63'b0, kill_wb}, 64'h0);
        tick();

        // IRQ arrives during a handler, taken after ERET
        drive(64'h44, 1, 0, 0, 2'd0, 0); tick();
        for (int i = 0; i < 5; i++) begin drive(64'hD8 + 64'(4*i), 0, 0, 0, 2'd0, 1); tick(); end
        drive(64'hF0, 0, 1, 0, 2'd0, 1); tick();
        drive(64'h44, 0, 0, 0, 2'd0, 1);
        chk("irq_exc", {63'b0, exc_taken}, 64'h1);
        tick();
        drive(64'hD8, 0, 0, 1, 2'd1, 1); chk("irq_esr", mrs_data, 64'h2);
        drive(64'hD8, 0, 0, 1, 2'd0, 1); chk("irq_elr", mrs_data, 64'h44);
        drive(64'hD8, 0, 0, 1, 2'd2, 1); chk("irq_cnt", mrs_data, 64'h3);
        tick();
        drive(64'hDC, 0, 1, 0, 2'd0, 1); tick();
        for (int i = 0; i < 6; i++) begin
            drive(64'h44 + 64'(4*i), 0, 0, 0, 2'd0, 1);
            chk("irq_held", {63'b0, exc_taken}, 64'h0);
            tick();
        end

        // ERET outside a handler
        drive(64'h80, 0, 1, 0, 2'd0, 0); chk("eret_run", {63'b0, exc_taken}, 64'h1); tick();
        drive(64'hD8, 0, 0, 1, 2'd1, 0); chk("eret_run_esr", mrs_data, 64'h1);
        drive(64'hD8, 0, 0, 1, 2'd0, 0); chk("eret_run_elr", mrs_data, 64'h80);

        // Double fault into lockup, then reset out of it
        drive(64'hD8, 1, 0, 0, 2'd0, 0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(64'h100 + 64'(4*i), 0, 0, 1, 2'd1, 0);
            chk("lk_kill", {63'b0, kill_wb}, 64'h1);
            chk("lk_esr", mrs_data, 64'h3);
            tick();
        end
        do_reset();

        // Counter saturation
        for (int i = 0; i < 20; i++) begin
            drive(64'h200, 1, 0, 0, 2'd0, 0); tick();
            drive(64'hD8, 0, 1, 0, 2'd0, 0); tick();
        end
        drive(64'h200, 0, 0, 1, 2'd2, 0);
        chk("cnt_sat", mrs_data, 64'hF);
        tick();

        // Random phase
        lk = 0;
        for (int c = 0; c < 3000; c++) begin
            if (lk > 5 || $urandom_range(0, 199) == 0) begin
                do_reset();
                lk = 0;
            end else begin
                drive({32'($urandom), 32'($urandom) & 32'hFFFF_FFFC},
                      $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                      1'($urandom), 2'($urandom),
                      ($urandom_range(0, 9) == 0) ? ~ext_irq : ext_irq);
                tick();
                lk = (m_st == 2) ? lk + 1 : 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
